irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: small priority interrupt controller sitting between up to eight
// device interrupt lines and a CPU with a single edge-detected irq input.
//
// Rising edges on intin latch into a pending register. Pending bits that
// are enabled by the mask are eligible. The lowest-index eligible source
// wins when the CPU acknowledges. A three-state handshake
// (IDLE -> REQ -> SERV) issues one irq pulse per interrupt and tracks the
// in-service source until the CPU returns from the interrupt.
//
// Ports
//   clk       in   1        sole clock, rising edge
//   rst       in   1        synchronous reset, active-low
//   intin     in   NUM_SRC  device interrupt lines, bit 0 highest priority
//   int_ack   in   1        CPU interrupt-acknowledge strobe
//   rti       in   1        CPU return-from-interrupt strobe
//   stb       in   1        IO select for this device
//   wr        in   1        IO write (1) / read (0) while stb=1
//   adr       in   2        register select
//   data_in   in   32       IO write data
//   data_out  out  32       IO read data (combinational, 0 when stb=0)
//   ack       out  1        IO acknowledge, mirrors stb
//   irq       out  1        registered one-cycle interrupt request
//
// Register map
//   0  R: pending          W: write-1-to-clear pending
//   1  R/W: enable mask
//   2  R: {active, spur, isn[2:0]}   W: ignored
//   3  R: 0                W: set pending (software trigger)
`timescale 1ns/1ps

module irq_ctrl #(
  parameter int         NUM_SRC   = 8,
  parameter logic [7:0] MASK_INIT = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] intin,
  input  logic               int_ack,
  input  logic               rti,
  input  logic               stb,
  input  logic               wr,
  input  logic [1:0]         adr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               ack,
  output logic               irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_SERV = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_irq;
  logic [NUM_SRC-1:0] r_intin_q;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_mask;
  logic [2:0]         r_isn;
  logic               r_spur;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_elig;
  logic [2:0]         w_sel;
  logic               w_none;
  logic               w_take;
  logic               w_wr;
  logic [NUM_SRC-1:0] w_set;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [31:0]        w_rdata;
  logic               w_unused;

  // Lowest-index set bit; returns 0 for an all-zero vector, which is what
  // ends up in isn on a spurious acknowledge.
  function automatic logic [2:0] f_lowest(input logic [NUM_SRC-1:0] v);
    f_lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = 3'(i);
    end
  endfunction

  assign w_edge = intin & ~r_intin_q;
  assign w_elig = r_pend & r_mask;
  assign w_sel  = f_lowest(w_elig);
  assign w_none = (w_elig == '0);
  assign w_take = (r_state == S_REQ) && int_ack;
  assign w_wr   = stb && wr;

  // Only the low NUM_SRC data bits reach any register.
  assign w_unused = ^data_in;

  // Pending update: clears are applied first and sets OR'd on top, so a
  // set and a clear of the same bit in one cycle leaves the bit set.
  always_comb begin
    w_set = w_edge;
    if (w_wr && (adr == 2'd3)) w_set = w_set | data_in[NUM_SRC-1:0];

    w_clr = '0;
    if (w_wr && (adr == 2'd0)) w_clr = data_in[NUM_SRC-1:0];
    if (w_take && !w_none) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_sel == 3'(i)) w_clr[i] = 1'b1;
      end
    end

    w_pend_nxt = (r_pend & ~w_clr) | w_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_irq     <= 1'b0;
      r_intin_q <= '0;
      r_pend    <= '0;
      r_mask    <= MASK_INIT[NUM_SRC-1:0];
      r_isn     <= '0;
      r_spur    <= 1'b0;
    end else begin
      r_intin_q <= intin;
      r_pend    <= w_pend_nxt;
      if (w_wr && (adr == 2'd1)) r_mask <= data_in[NUM_SRC-1:0];

      // irq is only ever raised on the IDLE->REQ transition, so it is
      // high for exactly the first cycle of REQ.
      r_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_none) begin
            r_state <= S_REQ;
            r_irq   <= 1'b1;
          end
        end
        S_REQ: begin
          // The CPU may take arbitrarily long to acknowledge; if software
          // cleared or masked everything meanwhile, report a spurious ack.
          if (int_ack) begin
            r_state <= S_SERV;
            r_isn   <= w_sel;
            r_spur  <= w_none;
          end
        end
        S_SERV: begin
          if (rti) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (stb) begin
      case (adr)
        2'd0:    w_rdata[NUM_SRC-1:0] = r_pend;
        2'd1:    w_rdata[NUM_SRC-1:0] = r_mask;
        2'd2:    w_rdata[4:0] = {(r_state == S_SERV), r_spur, r_isn};
        default: w_rdata = '0;
      endcase
    end
  end

  assign data_out = w_rdata;
  assign ack      = stb;
  assign irq      = r_irq;

endmodule
